regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (rd_a, rd, write) between two writeback requesters: req0 (ALU writeback) and req1 (memory load writeback).
- Valid/ready handshake per requester; round-robin arbitration; one registered write issued per cycle.
- Sits between the execute/memory stages and the 64x32 register file, which commits on the negedge of the cycle in which write is high.
- Provides a forwarding compare so readers see a write that is issued but not yet committed.

---
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Optional REG_ZERO_LOCK_EN: transfers to address 0 are accepted but never written or forwarded.
module regfile_wb_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] d0,
  output logic          rdy0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic          rdy1,
  output logic          write,
  output logic [AW-1:0] rd_a,
  output logic [DW-1:0] rd,
  input  logic [AW-1:0] fwd_a,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [CW-1:0] stall0,
  output logic [CW-1:0] stall1
);

  localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

  // last remembers the most recent winner; reset to 1 so requester 0 wins first contention
  logic          last;
  logic          g0;
  logic          g1;
  logic          xfer;
  logic [AW-1:0] sel_a;
  logic [DW-1:0] sel_d;
  logic          wr_en;
  logic          fwd_match;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        g0 = last;
        g1 = !last;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
  end

  assign rdy0  = g0;
  assign rdy1  = g1;
  assign xfer  = g0 || g1;
  assign sel_a = g1 ? a1 : a0;
  assign sel_d = g1 ? d1 : d0;

`ifdef REG_ZERO_LOCK_EN
  assign wr_en     = (sel_a != '0);
  assign fwd_match = (rd_a == fwd_a) && (fwd_a != '0);
`else
  assign wr_en     = 1'b1;
  assign fwd_match = (rd_a == fwd_a);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write <= 1'b0;
      rd_a  <= '0;
      rd    <= '0;
      last  <= 1'b1;
    end else if (xfer) begin
      write <= wr_en;
      rd_a  <= sel_a;
      rd    <= sel_d;
      last  <= g1;
    end else begin
      write <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall0 <= '0;
      stall1 <= '0;
    end else begin
      if (v0 && !g0 && stall0 != STALL_MAX) stall0 <= stall0 + CW'(1);
      if (v1 && !g1 && stall1 != STALL_MAX) stall1 <= stall1 + CW'(1);
    end
  end

  // Forwarding looks at the registered write so readers see it before the negedge commit
  assign fwd_hit  = write && fwd_match;
  assign fwd_data = fwd_hit ? rd : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model with its own register-file image.
module tb_regfile_wb_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          v0, v1;
  logic [AW-1:0] a0, a1, fwd_a;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, write, fwd_hit;
  logic [AW-1:0] rd_a;
  logic [DW-1:0] rd, fwd_data;
  logic [CW-1:0] stall0, stall1;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1),
    .write(write), .rd_a(rd_a), .rd(rd),
    .fwd_a(fwd_a), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .stall0(stall0), .stall1(stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the DUT: commits on the negedge of a cycle with write high
  logic [DW-1:0] tb_rf [64];
  initial for (int i = 0; i < 64; i++) tb_rf[i] = '0;
  always @(negedge clk) if (write) tb_rf[rd_a] <= rd;

  // Reference model state
  int            m_last;
  bit            m_write;
  logic [AW-1:0] m_rd_a;
  logic [DW-1:0] m_rd;
  int            m_st0, m_st1;
  logic [DW-1:0] m_rf [64];
  int            last_g;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit nv0, input logic [AW-1:0] na0, input logic [DW-1:0] nd0,
                               input bit nv1, input logic [AW-1:0] na1, input logic [DW-1:0] nd1,
                               input logic [AW-1:0] nfa);
    v0 = nv0; a0 = na0; d0 = nd0;
    v1 = nv1; a1 = na1; d1 = nd1;
    fwd_a = nfa;
  endtask

  // Winner: the lone valid requester, or under contention whoever did not win last
  function automatic int pick(input bit pv0, input bit pv1, input int prev);
    if (pv0 && pv1) return (prev == 0) ? 1 : 0;
    if (pv0) return 0;
    if (pv1) return 1;
    return -1;
  endfunction

  function automatic bit zero_locked(input logic [AW-1:0] addr);
`ifdef REG_ZERO_LOCK_EN
    return addr == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_last = 1; m_write = 0; m_rd_a = '0; m_rd = '0; m_st0 = 0; m_st1 = 0;
  endtask

  // Entered and left at posedge+1: checks near the negedge, model advances at the posedge
  task automatic step();
    int g;
    bit exp_hit;
    @(negedge clk);
    if (m_write) m_rf[m_rd_a] = m_rd;
    #1;
    g = pick(v0, v1, m_last);
    exp_hit = m_write && (m_rd_a == fwd_a) && !zero_locked(fwd_a);
    checkOutput("rdy0", rdy0, (g == 0));
    checkOutput("rdy1", rdy1, (g == 1));
    checkOutput("write", write, m_write);
    checkOutput("rd_a", rd_a, m_rd_a);
    checkOutput("rd", rd, m_rd);
    checkOutput("stall0", stall0, m_st0);
    checkOutput("stall1", stall1, m_st1);
    checkOutput("fwd_hit", fwd_hit, exp_hit);
    checkOutput("fwd_data", fwd_data, exp_hit ? m_rd : '0);
    checkOutput("rf_at_rd_a", tb_rf[m_rd_a], m_rf[m_rd_a]);
    checkOutput("rf0", tb_rf[0], m_rf[0]);
    @(posedge clk);
    if (v0 && g != 0 && m_st0 < SMAX) m_st0++;
    if (v1 && g != 1 && m_st1 < SMAX) m_st1++;
    if (g >= 0) begin
      m_last  = g;
      m_rd_a  = (g == 1) ? a1 : a0;
      m_rd    = (g == 1) ? d1 : d0;
      m_write = !zero_locked(m_rd_a);
    end else begin
      m_write = 0;
    end
    last_g = g;
    #1;
  endtask

  // Asynchronous reset pulse between edges; takes effect immediately
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_write", write, 0);
    checkOutput("rst_rdy0", rdy0, 0);
    checkOutput("rst_rdy1", rdy1, 0);
    checkOutput("rst_stall0", stall0, 0);
    checkOutput("rst_stall1", stall1, 0);
    checkOutput("rst_rd_a", rd_a, 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_rf[i] = '0;
    model_reset();
    last_g = -1;
    rst = 1'b1;
    applyStimulus(0, '0, '0, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    checkOutput("init_write", write, 0);
    checkOutput("init_rd", rd, 0);
    rst = 1'b0;

    // Reset while a write is in flight, then first contention goes to req0
    $display("[TB] reset mid-transfer");
    applyStimulus(1, 6'd5, 32'hAAAA5555, 0, '0, '0, 6'd5);
    step();
    checkOutput("t1_write_before_rst", write, 1);
    doReset();
    checkOutput("t1_write_after_rst", write, 0);
    applyStimulus(1, 6'd1, 32'h10, 1, 6'd2, 32'h20, '0);
    #1 checkOutput("t1_first_grant", rdy0, 1);
    step();
    checkOutput("t1_rd_a", rd_a, 1);

    // Single requester stream
    $display("[TB] single requester stream");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, '0, 1, AW'(7 + i), DW'(1 + i), '0);
      step();
      checkOutput("t2_write", write, 1);
      checkOutput("t2_rd_a", rd_a, 7 + i);
      checkOutput("t2_rd", rd, 1 + i);
    end

    // Continuous contention alternates grants
    $display("[TB] contention");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, AW'(20 + i), DW'(100 + i), 1, AW'(40 + i), DW'(200 + i), '0);
      step();
      checkOutput("t3_order", last_g, i % 2);
    end
    checkOutput("t3_stall0", stall0, 2);
    checkOutput("t3_stall1", stall1, 2);

    // Same address from both requesters
    $display("[TB] same-address ordering");
    doReset();
    applyStimulus(1, 6'd3, 32'h11, 1, 6'd3, 32'h22, '0);
    step();
    checkOutput("t4_first", rd, 32'h11);
    applyStimulus(0, '0, '0, 1, 6'd3, 32'h22, '0);
    step();
    checkOutput("t4_second", rd, 32'h22);
    applyStimulus(0, '0, '0, 0, '0, '0, '0);
    step();
    checkOutput("t4_rf3", tb_rf[3], 32'h22);

    // Forwarding of an issued-but-uncommitted write
    $display("[TB] forwarding");
    doReset();
    applyStimulus(1, 6'd12, 32'hDEADBEEF, 0, '0, '0, 6'd12);
    step();
    checkOutput("t5_hit", fwd_hit, 1);
    checkOutput("t5_data", fwd_data, 32'hDEADBEEF);
    applyStimulus(0, '0, '0, 0, '0, '0, 6'd13);
    #1;
    checkOutput("t5_miss", fwd_hit, 0);
    checkOutput("t5_miss_data", fwd_data, 0);
    step();

    // Write to register 0
    $display("[TB] register 0 write");
    doReset();
    applyStimulus(1, 6'd0, 32'hFFFFFFFF, 0, '0, '0, 6'd0);
    #1 checkOutput("t6_rdy0", rdy0, 1);
    step();
`ifdef REG_ZERO_LOCK_EN
    checkOutput("t6_write", write, 0);
`else
    checkOutput("t6_write", write, 1);
`endif
    applyStimulus(0, '0, '0, 0, '0, '0, '0);
    step();
`ifdef REG_ZERO_LOCK_EN
    checkOutput("t6_rf0", tb_rf[0], 0);
`else
    checkOutput("t6_rf0", tb_rf[0], 32'hFFFFFFFF);
`endif

    // Long contention drives both stall counters into saturation
    $display("[TB] stall saturation");
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, AW'(i), DW'(i), 1, AW'(i + 1), DW'(i + 1), '0);
      step();
    end
    checkOutput("sat_stall0", stall0, SMAX);
    checkOutput("sat_stall1", stall1, SMAX);

    // Random traffic: requesters hold their request until granted
    $display("[TB] random traffic");
    doReset();
    applyStimulus(0, '0, '0, 0, '0, '0, '0);
    last_g = -1;
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] fa;
      if (last_g == 0 || !v0) begin
        v0 = ($urandom_range(0, 99) < 70);
        a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        d0 = $urandom;
      end
      if (last_g == 1 || !v1) begin
        v1 = ($urandom_range(0, 99) < 70);
        a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        d1 = $urandom;
      end
      fa = $urandom_range(0, 1) ? m_rd_a : AW'($urandom);
      fwd_a = fa;
      if ($urandom_range(0, 99) == 0) doReset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
